// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix receive path: FSM state codes, frame
// constants and the element-count helper used by the loader and control unit.
package matrix_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_GET_SIZE = 3'd1;
  localparam logic [ST_W-1:0] ST_LOAD_A   = 3'd2;
  localparam logic [ST_W-1:0] ST_LOAD_B   = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE     = 3'd4;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned MAX_N_DEF     = 8;
  localparam int unsigned MAX_N_LIMIT   = 15;

  // Elements per matrix; 15*15 = 225 still fits in 8 bits.
  function automatic logic [7:0] elem_count(input logic [3:0] n);
    return 8'(n) * 8'(n);
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while run is high and flags
// expiry once the count reaches TIMEOUT_CYC-1 without a kick.
module byte_timeout #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired_q, expired_d;

  // Saturate at TIMEOUT_CYC so a stalled consumer never sees a wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (!run || kick) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(TIMEOUT_CYC)) begin
      cnt_d = cnt_q + CW'(1);
    end
    expired_d = run && !kick && (cnt_d == CW'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/matrix_rx_loader.sv
// Parses SYNC / size / A / B frames from the UART byte stream and emits
// registered write strobes into the A and B matrix buffers.
module matrix_rx_loader
  import matrix_pkg::*;
#(
  parameter int unsigned MAX_N       = MAX_N_DEF,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_enable,
  output logic [3:0] matrix_size,
  output logic       a_we,
  output logic       b_we,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       load_done,
  output logic       frame_err
);

  logic [ST_W-1:0] state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      size_q, size_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            a_we_q, a_we_d;
  logic            b_we_q, b_we_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic accept;
  logic last_elem;
  logic to_run;
  logic to_expired;

  assign accept    = rx_valid && rx_enable;
  assign last_elem = (cnt_q == (elem_count(size_q) - 8'd1));
  assign to_run    = (state_q == ST_GET_SIZE) || (state_q == ST_LOAD_A) ||
                     (state_q == ST_LOAD_B);

  byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .run    (to_run),
    .kick   (accept),
    .expired(to_expired)
  );

  // Next-state and registered-output decode; an accepted byte beats a timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    addr_d  = addr_q;
    data_d  = data_q;
    a_we_d  = 1'b0;
    b_we_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) state_d = ST_GET_SIZE;
      end
      ST_GET_SIZE: begin
        if (accept) begin
          if ((rx_data != 8'd0) && (rx_data <= 8'(MAX_N))) begin
            size_d  = 4'(rx_data);
            cnt_d   = 8'd0;
            state_d = ST_LOAD_A;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_A, ST_LOAD_B: begin
        if (accept) begin
          a_we_d = (state_q == ST_LOAD_A);
          b_we_d = (state_q == ST_LOAD_B);
          addr_d = cnt_q;
          data_d = rx_data;
          cnt_d  = cnt_q + 8'd1;
          if (last_elem) begin
            cnt_d   = 8'd0;
            state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_DONE;
            done_d  = (state_q == ST_LOAD_B);
          end
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      size_q  <= 4'd0;
      addr_q  <= 8'd0;
      data_q  <= 8'd0;
      a_we_q  <= 1'b0;
      b_we_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      a_we_q  <= a_we_d;
      b_we_q  <= b_we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign matrix_size = size_q;
  assign a_we        = a_we_q;
  assign b_we        = b_we_q;
  assign wr_addr     = addr_q;
  assign wr_data     = data_q;
  assign load_done   = done_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_matrix_rx_loader.sv
// Directed and randomized frame bench for matrix_rx_loader; expected writes
// are derived from the frame byte list, observed strobes collected by a monitor.
module tb_matrix_rx_loader;

  localparam int unsigned TO   = 40;
  localparam int unsigned MAXN = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_enable;
  logic [3:0] matrix_size;
  logic       a_we, b_we;
  logic [7:0] wr_addr, wr_data;
  logic       load_done, frame_err;

  always #5 clk = ~clk;

  matrix_rx_loader #(
    .MAX_N      (MAXN),
    .TIMEOUT_CYC(TO),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_enable  (rx_enable),
    .matrix_size(matrix_size),
    .a_we       (a_we),
    .b_we       (b_we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .load_done  (load_done),
    .frame_err  (frame_err)
  );

  int total = 0;
  int bad   = 0;

  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];
  logic [7:0]  tx_q[$];
  int          done_cnt  = 0;
  int          err_cnt   = 0;
  int          both_cnt  = 0;
  logic        last_done_b;
  logic [7:0]  last_done_addr;

  int ws, e0, d0;
  int cur_size;

  // Monitor: record every strobe as {is_b, addr, data}.
  always @(negedge clk) begin
    if (a_we === 1'b1 && b_we === 1'b1) both_cnt++;
    if (a_we === 1'b1) obs_q.push_back({1'b0, wr_addr, wr_data});
    if (b_we === 1'b1) obs_q.push_back({1'b1, wr_addr, wr_data});
    if (load_done === 1'b1) begin
      done_cnt++;
      last_done_b    = b_we;
      last_done_addr = wr_addr;
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One byte for one cycle, then a gap filled with disabled (ignored) traffic.
  task automatic send(input logic [7:0] b, input logic en, input int gap);
    rx_valid  = 1'b1;
    rx_data   = b;
    rx_enable = en;
    @(negedge clk);
    repeat (gap) begin
      rx_valid  = 1'($urandom_range(0, 1));
      rx_enable = 1'b0;
      rx_data   = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic build(input int n);
    tx_q = {};
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'(n));
    for (int i = 0; i < 2 * n * n; i++) tx_q.push_back(8'($urandom));
  endtask

  // Expected writes follow directly from the frame layout.
  task automatic expect_from_tx();
    int n;
    n = int'(tx_q[1]);
    for (int i = 0; i < n * n; i++) exp_q.push_back({1'b0, 8'(i), tx_q[2 + i]});
    for (int i = 0; i < n * n; i++) exp_q.push_back({1'b1, 8'(i), tx_q[2 + n * n + i]});
  endtask

  task automatic send_all(input logic en, input int maxgap, input bit last_tight);
    for (int i = 0; i < tx_q.size(); i++) begin
      send(tx_q[i], en,
           (last_tight && i == tx_q.size() - 1) ? 0 : int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic begin_scn();
    ws    = obs_q.size();
    e0    = err_cnt;
    d0    = done_cnt;
    exp_q = {};
  endtask

  task automatic end_scn(input string tag, input int exp_err, input int exp_done,
                         input int exp_size);
    idle(4);
    chk({tag, "/nwr"}, obs_q.size() - ws, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (ws + i < obs_q.size()) chk({tag, "/wr"}, obs_q[ws + i], exp_q[i]);
    end
    chk({tag, "/err"}, err_cnt - e0, exp_err);
    chk({tag, "/done"}, done_cnt - d0, exp_done);
    chk({tag, "/size"}, matrix_size, exp_size);
    chk({tag, "/overlap"}, both_cnt, 0);
    if (exp_done > 0 && exp_q.size() > 0)
      chk({tag, "/donepos"}, {last_done_b, last_done_addr}, {1'b1, exp_q[$][15:8]});
  endtask

  initial begin
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_enable = 1'b0;
    rx_data   = 8'h00;
    idle(3);
    chk("rst/size", matrix_size, 0);
    chk("rst/a_we", a_we, 0);
    chk("rst/b_we", b_we, 0);
    chk("rst/addr", wr_addr, 0);
    chk("rst/data", wr_data, 0);
    chk("rst/done", load_done, 0);
    chk("rst/err", frame_err, 0);
    rst = 1'b0;
    idle(2);

    // Reference 2x2 frame.
    begin_scn();
    tx_q = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    expect_from_tx();
    send_all(1'b1, 2, 1'b0);
    end_scn("f2x2", 0, 1, 2);

    // Leading junk dropped, then 1x1 frame.
    begin_scn();
    send(8'h00, 1'b1, 1);
    send(8'hFF, 1'b1, 0);
    tx_q = {8'hA5, 8'h01, 8'h09, 8'h0A};
    expect_from_tx();
    send_all(1'b1, 1, 1'b0);
    end_scn("junk1x1", 0, 1, 1);
    cur_size = 1;

    // Oversize and zero sizes rejected; size held.
    begin_scn();
    send(8'hA5, 1'b1, 1);
    send(8'h09, 1'b1, 2);
    end_scn("size9", 1, 0, cur_size);
    begin_scn();
    send(8'hA5, 1'b1, 0);
    send(8'h00, 1'b1, 2);
    end_scn("size0", 1, 0, cur_size);

    // Largest dimension, with a SYNC byte landing in the DONE cycle.
    begin_scn();
    build(MAXN);
    expect_from_tx();
    send_all(1'b1, 1, 1'b1);
    send(8'hA5, 1'b1, 0);
    send(8'h01, 1'b1, 0);
    send(8'h07, 1'b1, 1);
    end_scn("maxn+done", 0, 1, MAXN);
    cur_size = MAXN;

    // Inter-byte timeout inside LOAD_A.
    begin_scn();
    tx_q = {8'hA5, 8'h02, 8'h01, 8'h02};
    send_all(1'b1, 2, 1'b0);
    exp_q.push_back({1'b0, 8'd0, 8'h01});
    exp_q.push_back({1'b0, 8'd1, 8'h02});
    idle(TO + 10);
    end_scn("timeout", 1, 0, 2);
    cur_size = 2;

    // Byte arriving on the expiry cycle wins.
    begin_scn();
    send(8'hA5, 1'b1, 0);
    send(8'h01, 1'b1, TO - 1);
    send(8'h33, 1'b1, 0);
    send(8'h44, 1'b1, 1);
    exp_q.push_back({1'b0, 8'd0, 8'h33});
    exp_q.push_back({1'b1, 8'd0, 8'h44});
    end_scn("torace", 0, 1, 1);

    // Reset after the third A element.
    begin_scn();
    send(8'hA5, 1'b1, 1);
    send(8'h03, 1'b1, 1);
    send(8'h11, 1'b1, 1);
    send(8'h12, 1'b1, 0);
    send(8'h13, 1'b1, 0);
    exp_q.push_back({1'b0, 8'd0, 8'h11});
    exp_q.push_back({1'b0, 8'd1, 8'h12});
    exp_q.push_back({1'b0, 8'd2, 8'h13});
    rst = 1'b1;
    send(8'h14, 1'b1, 1);
    rst = 1'b0;
    send(8'h15, 1'b1, 0);
    send(8'h16, 1'b1, 1);
    end_scn("rstmid", 0, 0, 0);
    begin_scn();
    tx_q = {8'hA5, 8'h01, 8'h03, 8'h04};
    expect_from_tx();
    send_all(1'b1, 1, 1'b0);
    end_scn("postrst", 0, 1, 1);
    cur_size = 1;

    // Disabled frame ignored, identical enabled frame loads.
    build(3);
    begin_scn();
    send_all(1'b0, 1, 1'b0);
    end_scn("disabled", 0, 0, cur_size);
    begin_scn();
    expect_from_tx();
    send_all(1'b1, 2, 1'b0);
    end_scn("enabled", 0, 1, 3);

    // Randomized frames.
    for (int k = 0; k < 6; k++) begin
      int n;
      n = int'($urandom_range(1, MAXN));
      begin_scn();
      build(n);
      expect_from_tx();
      send_all(1'b1, 3, 1'b0);
      end_scn("rand", 0, 1, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_rx_loader.md
MATRIX_RX_LOADER -- requirements
Module: matrix_rx_loader

Interface
REQ-001 Parameter MAX_N, default 8: largest accepted matrix dimension (1..15).
REQ-002 Parameter TIMEOUT_CYC, default 100000: maximum clk cycles allowed between bytes inside a frame.
REQ-003 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-004 clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx_valid  input  1  one-cycle strobe from UART RX: rx_data is valid.
REQ-007 rx_data  input  8  received byte.
REQ-008 rx_enable  input  1  from control unit; when 0, rx_valid is ignored.
REQ-009 matrix_size  output  4  accepted dimension N, held until the next accepted size.
REQ-010 a_we  output  1  write strobe to matrix A buffer.
REQ-011 b_we  output  1  write strobe to matrix B buffer.
REQ-012 wr_addr  output  8  row-major element index within the current matrix, 0..N*N-1.
REQ-013 wr_data  output  8  element byte.
REQ-014 load_done  output  1  one-cycle pulse: both matrices fully written.
REQ-015 frame_err  output  1  one-cycle pulse: bad size or inter-byte timeout; frame discarded.

Function
REQ-016 A byte is accepted only when rx_valid=1 and rx_enable=1.
REQ-017 Frame format: SYNC_BYTE, size byte N, N*N bytes of A, then N*N bytes of B, all row-major.
REQ-018 States: IDLE, GET_SIZE, LOAD_A, LOAD_B, DONE.
REQ-019 IDLE: an accepted byte equal to SYNC_BYTE -> GET_SIZE; any other byte is dropped silently.
REQ-020 GET_SIZE: accepted byte with value 1..MAX_N -> latch matrix_size, clear element counter, go to LOAD_A; value 0 or >MAX_N -> frame_err pulse, go to IDLE, matrix_size unchanged.
REQ-021 LOAD_A: each accepted byte -> a_we=1 for exactly one cycle, in the cycle after acceptance, with wr_addr=counter and wr_data=byte; counter then increments.
REQ-022 LOAD_A: acceptance of element N*N-1 -> counter cleared to 0, go to LOAD_B.
REQ-023 LOAD_B: behaves as LOAD_A but drives b_we; acceptance of element N*N-1 -> DONE.
REQ-024 DONE lasts one cycle; load_done=1 in the same cycle as the final b_we; then -> IDLE.
REQ-025 Bytes accepted while in DONE are dropped and are not treated as SYNC.
REQ-026 a_we and b_we are never asserted in the same cycle; at most one write per accepted byte.
REQ-027 Timeout counter resets on every accepted byte, counts only in GET_SIZE, LOAD_A and LOAD_B, and is cleared whenever the FSM is in IDLE.
REQ-028 When the timeout counter reaches TIMEOUT_CYC-1 with no byte accepted: frame_err pulse, go to IDLE, and any partial data is left in the buffers; load_done is not asserted.
REQ-029 If an accepted byte and timeout expiry fall in the same cycle, the byte wins and the timeout is cleared.
REQ-030 N*N is computed in 8 bits (maximum 225); counter width is 8 bits and never wraps within a frame.
REQ-031 All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-032 rst=1 forces on the next edge: state IDLE; counter 0; timeout 0; matrix_size 0; a_we, b_we, load_done and frame_err 0; wr_addr 0; wr_data 0.
REQ-033 Reset mid-frame abandons the frame, issues no further write strobes from the next edge, and raises no frame_err.

Structure
REQ-034 State encoding, SYNC_BYTE default and the MAX_N limit belong in shared package matrix_pkg, used by the control unit and this block.
REQ-035 The inter-byte watchdog is one sub-module, byte_timeout (inputs clk, rst, run, kick; output expired).

Verification
REQ-036 Frame A5,02,1,2,3,4,5,6,7,8 -> a_we at addr 0..3 with data 1..4, b_we at addr 0..3 with data 5..8, matrix_size=2, one load_done coincident with b_we at addr 3.
REQ-037 Bytes 00,FF then A5,01,09,0A -> first two dropped; a_we addr0=09, b_we addr0=0A, load_done.
REQ-038 A5,09 with MAX_N=8 -> frame_err pulse, no writes, matrix_size keeps its previous value; next valid frame loads normally.
REQ-039 A5,02,1,2 then idle for TIMEOUT_CYC cycles -> exactly one frame_err, return to IDLE, no load_done.
REQ-040 rst asserted after the third A element -> no further a_we, state IDLE; new frame A5,01,03,04 completes.
REQ-041 rx_enable=0 during a full frame -> no strobes and no errors; the same frame with rx_enable=1 loads.
